// File: rtl/mvm_pkg.sv
// Shared types and constants for the matrix-vector multiply controller.
package mvm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_X,
    S_COMPUTE,
    S_DRAIN,
    S_DONE,
    S_OUTPUT
  } state_t;

  localparam int DEF_M        = 4;
  localparam int DEF_N        = 4;
  localparam int DEF_PIPE_LAT = 2;

  // Index width that never collapses to zero bits for a size-1 range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvm_ctrl_cnt.sv
// Modulo counter with enable, synchronous clear and a wrap flag on the final count.
module mvm_ctrl_cnt
  import mvm_pkg::*;
#(
  parameter int MOD = 4,
  parameter int W   = idx_w(MOD)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == W'(MOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || wrap) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mvm_ctrl.sv
// Sequencer for an M x N matrix-vector multiply: load, compute, drain, output.
// Optional sticky dropped-command flag enabled by defining MVM_CTRL_CMD_ERR_EN.
module mvm_ctrl
  import mvm_pkg::*;
#(
  parameter int M        = DEF_M,
  parameter int N        = DEF_N,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    loadMatrix,
  input  logic                    loadVector,
  input  logic                    start,
  output logic [idx_w(M*N)-1:0]   addr_a,
  output logic                    wr_en_a,
  output logic [idx_w(N)-1:0]     addr_x,
  output logic                    wr_en_x,
  output logic                    acc_clear,
  output logic                    acc_en,
  output logic                    y_wr,
  output logic [idx_w(M)-1:0]     y_addr,
  output logic                    done,
  output logic                    out_valid,
  output logic [idx_w(M)-1:0]     out_sel,
  output logic                    busy
`ifdef MVM_CTRL_CMD_ERR_EN
  ,
  output logic                    cmd_err
`endif
);

  localparam int AW = idx_w(M*N);
  localparam int XW = idx_w(N);
  localparam int RW = idx_w(M);

  state_t          state;
  logic [XW-1:0]   k;
  logic [RW-1:0]   r;
  logic [RW-1:0]   o;
  logic            k_en, k_wrap, r_en, r_wrap, o_en, o_wrap;
  logic            issue;

  assign k_en  = (state == S_LOAD_A) || (state == S_LOAD_X) || (state == S_COMPUTE);
  assign r_en  = k_wrap && (state != S_LOAD_X);
  assign o_en  = (state == S_OUTPUT);
  assign issue = (state == S_COMPUTE);

  // Row counter only advances in matrix-walking states; all clear on exit.
  mvm_ctrl_cnt #(.MOD(N), .W(XW)) u_k (
    .clk(clk), .reset(reset), .en(k_en), .clr(!k_en), .cnt(k), .wrap(k_wrap)
  );
  mvm_ctrl_cnt #(.MOD(M), .W(RW)) u_r (
    .clk(clk), .reset(reset), .en(r_en),
    .clr(!((state == S_LOAD_A) || (state == S_COMPUTE))), .cnt(r), .wrap(r_wrap)
  );
  mvm_ctrl_cnt #(.MOD(M), .W(RW)) u_o (
    .clk(clk), .reset(reset), .en(o_en), .clr(!o_en), .cnt(o), .wrap(o_wrap)
  );

  // Issue-to-result delay line: valid is reset, payload is not.
  logic            vld_p   [PIPE_LAT];
  logic            first_p [PIPE_LAT];
  logic            last_p  [PIPE_LAT];
  logic [RW-1:0]   r_p     [PIPE_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIPE_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < PIPE_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    first_p[0] <= (k == XW'(0));
    last_p[0]  <= (k == XW'(N - 1));
    r_p[0]     <= r;
    for (int i = 1; i < PIPE_LAT; i++) begin
      first_p[i] <= first_p[i-1];
      last_p[i]  <= last_p[i-1];
      r_p[i]     <= r_p[i-1];
    end
  end

  logic y_wr_int, last_row;
  assign y_wr_int = vld_p[PIPE_LAT-1] && last_p[PIPE_LAT-1];
  assign last_row = (r_p[PIPE_LAT-1] == RW'(M - 1));

  // Control FSM; DRAIN ends when the final row's result leaves the delay line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (loadMatrix)      state <= S_LOAD_A;
          else if (loadVector) state <= S_LOAD_X;
          else if (start)      state <= S_COMPUTE;
        end
        S_LOAD_A:  if (r_wrap) state <= S_IDLE;
        S_LOAD_X:  if (k_wrap) state <= S_IDLE;
        S_COMPUTE: if (r_wrap) state <= S_DRAIN;
        S_DRAIN:   if (y_wr_int && last_row) state <= S_DONE;
        S_DONE:    state <= S_OUTPUT;
        S_OUTPUT:  if (o_wrap) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign wr_en_a   = (state == S_LOAD_A);
  assign addr_a    = ((state == S_LOAD_A) || issue) ? AW'(int'(r) * N + int'(k)) : '0;
  assign wr_en_x   = (state == S_LOAD_X);
  assign addr_x    = ((state == S_LOAD_X) || issue) ? k : '0;
  assign acc_en    = vld_p[0];
  assign acc_clear = vld_p[0] && first_p[0];
  assign y_wr      = y_wr_int;
  assign y_addr    = y_wr_int ? r_p[PIPE_LAT-1] : '0;
  assign done      = (state == S_DONE);
  assign out_valid = (state == S_OUTPUT);
  assign out_sel   = o;
  assign busy      = (state != S_IDLE);

`ifdef MVM_CTRL_CMD_ERR_EN
  logic cmd_drop;
  always_comb begin
    cmd_drop = 1'b0;
    if (state == S_IDLE)
      cmd_drop = (loadMatrix && (loadVector || start)) || (loadVector && start);
    else
      cmd_drop = loadMatrix || loadVector || start;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cmd_err <= 1'b0;
    else if (cmd_drop) cmd_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mvm_ctrl.sv
// Scoreboard bench for mvm_ctrl (M=N=4, PIPE_LAT=2): expected strobes queued, monitor compares.
module tb_mvm_ctrl;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int L  = 2;
  localparam int MN = M * N;

  logic       clk = 1'b0;
  logic       reset;
  logic       loadMatrix, loadVector, start;
  logic [3:0] addr_a;
  logic       wr_en_a;
  logic [1:0] addr_x;
  logic       wr_en_x, acc_clear, acc_en, y_wr;
  logic [1:0] y_addr;
  logic       done, out_valid;
  logic [1:0] out_sel;
  logic       busy;
`ifdef MVM_CTRL_CMD_ERR_EN
  logic       cmd_err;
`endif

  mvm_ctrl #(.M(M), .N(N), .PIPE_LAT(L)) dut (
    .clk(clk), .reset(reset),
    .loadMatrix(loadMatrix), .loadVector(loadVector), .start(start),
    .addr_a(addr_a), .wr_en_a(wr_en_a), .addr_x(addr_x), .wr_en_x(wr_en_x),
    .acc_clear(acc_clear), .acc_en(acc_en), .y_wr(y_wr), .y_addr(y_addr),
    .done(done), .out_valid(out_valid), .out_sel(out_sel), .busy(busy)
`ifdef MVM_CTRL_CMD_ERR_EN
    , .cmd_err(cmd_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kinds: 0 wr_en_a/addr_a, 1 wr_en_x/addr_x, 2 acc_en/acc_clear, 3 y_wr/y_addr, 4 done, 5 out_valid/out_sel
  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;
  ev_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic push(input int c, input int kind, input int val);
    ev_t e;
    e.cyc = c; e.kind = kind; e.val = val;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input int kind, input logic active, input int val);
    ev_t e;
    if (active) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL stray_strobe: kind %0d val %0d at cycle %0d, none expected", kind, val, cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.kind != kind || e.val != val) begin
          errors++;
          $display("FAIL strobe_match: got kind %0d val %0d cycle %0d expected kind %0d val %0d cycle %0d",
                   kind, val, cyc, e.kind, e.val, e.cyc);
        end
      end
    end
  endtask

  // Monitor: flags expected strobes that never came, then matches each active strobe.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_strobe: kind %0d val %0d due cycle %0d, now cycle %0d",
               q[0].kind, q[0].val, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    observe(0, wr_en_a,   int'(addr_a));
    observe(1, wr_en_x,   int'(addr_x));
    observe(2, acc_en,    int'(acc_clear));
    observe(3, y_wr,      int'(y_addr));
    observe(4, done,      0);
    observe(5, out_valid, int'(out_sel));
  end

  // Hand-derived compute sequence for start sampled at cycle base:
  // acc_en 2..17 (clear at 2,6,10,14), y_wr at 6,10,14,18 rows 0..3, done 19, out_sel 0..3 at 20..23.
  task automatic push_compute(input int base, input int last_t);
    for (int t = 0; t <= 23; t++) begin
      if (t <= last_t) begin
        if (t >= 2 && t <= 17) push(base + t, 2, ((t - 2) % 4 == 0) ? 1 : 0);
        if (t >= 6 && t <= 18 && (t - 6) % 4 == 0) push(base + t, 3, (t - 6) / 4);
        if (t == 19) push(base + t, 4, 0);
        if (t >= 20) push(base + t, 5, t - 20);
      end
    end
  endtask

  task automatic drive(input logic lm, input logic lv, input logic st, output int base);
    @(negedge clk);
    base = cyc;
    loadMatrix = lm; loadVector = lv; start = st;
  endtask

  task automatic release_cmds();
    @(negedge clk);
    loadMatrix = 1'b0; loadVector = 1'b0; start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic int outs_packed();
    return int'({addr_a, wr_en_a, addr_x, wr_en_x, acc_clear, acc_en, y_wr,
                 y_addr, done, out_valid, out_sel, busy});
  endfunction

  task automatic load_matrix_seq();
    int base;
    drive(1'b1, 1'b0, 1'b0, base);
    for (int i = 0; i < MN; i++) push(base + 1 + i, 0, i);
    release_cmds();
    wait_until(base + 16);
    chk("busy_last_load_a", int'(busy), 1);
    wait_until(base + 17);
    chk("busy_after_load_a", int'(busy), 0);
  endtask

  initial begin
    int base;
    reset = 1'b0;
    loadMatrix = 1'b0; loadVector = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_packed(), 0);
`ifdef MVM_CTRL_CMD_ERR_EN
    chk("reset_cmd_err", int'(cmd_err), 0);
`endif
    @(posedge clk); #1 reset = 1'b1;

    // Matrix load: 16 writes, then idle.
    load_matrix_seq();
`ifdef MVM_CTRL_CMD_ERR_EN
    chk("cmd_err_clean", int'(cmd_err), 0);
`endif

    // loadVector and start together: vector load only.
    drive(1'b0, 1'b1, 1'b1, base);
    for (int i = 0; i < N; i++) push(base + 1 + i, 1, i);
    release_cmds();
    wait_until(base + 5);
    chk("busy_after_load_x", int'(busy), 0);
    wait_until(base + 8);
`ifdef MVM_CTRL_CMD_ERR_EN
    chk("cmd_err_dropped_start", int'(cmd_err), 1);
`endif

    // Full compute with issue-address checks.
    drive(1'b0, 1'b0, 1'b1, base);
    push_compute(base, 99);
    release_cmds();
    for (int t = 1; t <= MN; t++) begin
      if (t > 1) @(negedge clk);
      chk("issue_addr_a", int'(addr_a), t - 1);
      chk("issue_addr_x", int'(addr_x), (t - 1) % N);
    end
    wait_until(base + 26);
    chk("idle_after_output", int'(busy), 0);

    // Repeated start and a loadMatrix during COMPUTE are ignored.
    drive(1'b0, 1'b0, 1'b1, base);
    push_compute(base, 99);
    release_cmds();
    wait_until(base + 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(base + 8);
    loadMatrix = 1'b1;
    @(negedge clk);
    loadMatrix = 1'b0;
    wait_until(base + 27);

    // Reset asserted in COMPUTE cycle 7: outputs drop at once, nothing further.
    drive(1'b0, 1'b0, 1'b1, base);
    push_compute(base, 6);
    release_cmds();
    wait_until(base + 6);
    @(posedge clk); #1 reset = 1'b0;
    #1 chk("midrun_reset_outputs", outs_packed(), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
`ifdef MVM_CTRL_CMD_ERR_EN
    chk("cmd_err_cleared", int'(cmd_err), 0);
`endif
    load_matrix_seq();
    repeat (30) @(negedge clk);

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mvm_ctrl.md
MVM_CTRL -- requirements
Module: mvm_ctrl

Interface
REQ-001 Parameter M, default 4, matrix rows / output vector length.
REQ-002 Parameter N, default 4, matrix columns / input vector length.
REQ-003 Parameter PIPE_LAT, default 2, cycles from read-address issue to accumulator result valid (range 1..4).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 loadMatrix / loadVector / start  in  1 each  one-cycle command pulses.
REQ-007 addr_a  out  clog2(M*N)  matrix memory address (write in LOAD_A, read in COMPUTE); wr_en_a  out  1.
REQ-008 addr_x  out  clog2(N)  vector memory address; wr_en_x  out  1.
REQ-009 acc_clear, acc_en  out  1 each  datapath accumulator controls.
REQ-010 y_wr  out  1, y_addr  out  clog2(M)  output-register write strobe and row index.
REQ-011 done  out  1  single-cycle completion pulse; out_valid  out  1, out_sel  out  clog2(M)  output mux select.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 States: IDLE, LOAD_A, LOAD_X, COMPUTE, DRAIN, DONE, OUTPUT.
REQ-014 IDLE command priority loadMatrix > loadVector > start; lower-priority simultaneous pulses dropped.
REQ-015 Commands arriving outside IDLE are ignored, no queuing.
REQ-016 loadMatrix -> LOAD_A next cycle; M*N cycles, wr_en_a=1, addr_a 0..M*N-1 row-major; -> IDLE after last word.
REQ-017 loadVector -> LOAD_X next cycle; N cycles, wr_en_x=1, addr_x 0..N-1; -> IDLE after last word.
REQ-018 start -> COMPUTE; M*N cycles issuing addr_a=r*N+k, addr_x=k, r outer, k inner.
REQ-019 acc_en asserted one cycle after each COMPUTE issue; acc_clear asserted with acc_en when delayed k==0.
REQ-020 y_wr asserted PIPE_LAT cycles after issue of k==N-1, y_addr=r of that row.
REQ-021 DRAIN lasts exactly PIPE_LAT cycles after last issue; -> DONE.
REQ-022 DONE lasts one cycle, done=1; -> OUTPUT.
REQ-023 OUTPUT lasts M cycles, out_valid=1, out_sel 0..M-1; -> IDLE.
REQ-024 start-to-done latency fixed: 1+M*N+PIPE_LAT cycles (start sampled cycle 0, done high cycle 1+M*N+PIPE_LAT).
REQ-025 All counters wrap to 0 on state exit; no address exceeds its range.
REQ-026 start without prior loads still runs full sequence (memory contents undefined, not a controller concern).

Reset
REQ-027 reset low -> IDLE immediately, all counters 0, all outputs 0, delay pipeline flushed.
REQ-028 reset mid-operation aborts with no further y_wr, done or out_valid; commands accepted first cycle after deassertion.

Configuration
REQ-029 MVM_CTRL_CMD_ERR_EN defined: adds output cmd_err (1 bit), sticky high after any command pulse ignored per REQ-014/015, cleared only by reset.
REQ-030 MVM_CTRL_CMD_ERR_EN undefined: no cmd_err port, no related logic.

Structure
REQ-031 Package mvm_pkg holds state enum typedef, default M/N/PIPE_LAT constants, index-width localparam functions.
REQ-032 One sub-module mvm_ctrl_cnt: parameterised modulo counter, enable, sync clear, wrap flag; instanced for r, k, out_sel.
REQ-033 Issue-to-result delay via PIPE_LAT-deep shift register of {valid, last_k, r}.

Verification
REQ-034 loadMatrix pulse -> wr_en_a high 16 cycles, addr_a 0..15, busy low cycle 17.
REQ-035 loadVector and start same cycle in IDLE -> LOAD_X only; start dropped; cmd_err=1 if macro defined.
REQ-036 start, PIPE_LAT=2 -> done high exactly cycle 19, y_wr at cycles 6,10,14,18 with y_addr 0..3, out_sel 0..3 cycles 20-23.
REQ-037 start pulsed again during COMPUTE -> ignored, single done pulse, timing unchanged.
REQ-038 reset low during COMPUTE cycle 7 -> all outputs 0 same cycle, no done; new loadMatrix after release accepted.
REQ-039 1000 random commands against mvm_4_4_8_1 datapath -> data_out equals reference y for every output.
